// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - decode, forwarding and ALU-operand bundle for the ID/EX stage
// The master drives decode, forwarding and pipeline control; the slave is the operand stage.
interface id_ex_operand_stage_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              stall;
   logic              flush;
   logic              id_valid;
   logic [XLEN-1:0]   id_pc;
   logic [XLEN-1:0]   id_rs1_data;
   logic [XLEN-1:0]   id_rs2_data;
   logic [XLEN-1:0]   id_imm;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_alu_src;
   logic [2:0]        id_alu_op;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              id_mem_write;
   logic [1:0]        id_result_src;

   logic [REG_AW-1:0] exm_rd;
   logic              exm_reg_write;
   logic [XLEN-1:0]   exm_result;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_reg_write;
   logic [XLEN-1:0]   wb_result;

   logic [XLEN-1:0]   alu_a;
   logic [XLEN-1:0]   alu_b;
   logic [2:0]        alu_op;
   logic [XLEN-1:0]   ex_store_data;
   logic [XLEN-1:0]   ex_pc;
   logic [XLEN-1:0]   ex_imm;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_valid;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic [1:0]        ex_result_src;
   logic              load_use_hazard;

   modport master (
      output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_alu_src, id_alu_op, id_reg_write,
             id_mem_read, id_mem_write, id_result_src,
             exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_result,
      input  alu_a, alu_b, alu_op, ex_store_data, ex_pc, ex_imm, ex_rd, ex_valid,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_result_src, load_use_hazard
   );

   modport slave (
      input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_alu_src, id_alu_op, id_reg_write,
             id_mem_read, id_mem_write, id_result_src,
             exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_result,
      output alu_a, alu_b, alu_op, ex_store_data, ex_pc, ex_imm, ex_rd, ex_valid,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_result_src, load_use_hazard
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with EX-stage operand forwarding
// Feeds the ALU directly and reports load-use hazards back to the hazard unit.
module id_ex_operand_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input logic                   clk,
   input logic                   rst_n,
   id_ex_operand_stage_if.slave  bus
);

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              alu_src;
      logic [2:0]        alu_op;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic [1:0]        result_src;
   } ex_regs_t;

   ex_regs_t ex_q, ex_d;

   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic            id_reads_rs2;

   // EX/MEM is younger than MEM/WB, so its result wins; x0 is never forwarded.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic [XLEN-1:0]   rf_data,
      input logic              exm_we,
      input logic [REG_AW-1:0] exm_dst,
      input logic [XLEN-1:0]   exm_val,
      input logic              wb_we,
      input logic [REG_AW-1:0] wb_dst,
      input logic [XLEN-1:0]   wb_val
   );
      logic [XLEN-1:0] sel;
      sel = rf_data;
      if (exm_we && (exm_dst != '0) && (exm_dst == src)) begin
         sel = exm_val;
      end else if (wb_we && (wb_dst != '0) && (wb_dst == src)) begin
         sel = wb_val;
      end
      return sel;
   endfunction

   always_comb begin
      ex_d = ex_q;
      if (bus.flush) begin
         ex_d = '0;
      end else if (!bus.stall) begin
         ex_d.valid      = bus.id_valid;
         ex_d.pc         = bus.id_pc;
         ex_d.rs1_data   = bus.id_rs1_data;
         ex_d.rs2_data   = bus.id_rs2_data;
         ex_d.imm        = bus.id_imm;
         ex_d.rs1        = bus.id_rs1;
         ex_d.rs2        = bus.id_rs2;
         ex_d.rd         = bus.id_rd;
         ex_d.alu_src    = bus.id_alu_src;
         ex_d.alu_op     = bus.id_alu_op;
         ex_d.reg_write  = bus.id_reg_write;
         ex_d.mem_read   = bus.id_mem_read;
         ex_d.mem_write  = bus.id_mem_write;
         ex_d.result_src = bus.id_result_src;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   always_comb begin
      rs1_fwd = fwd_sel(ex_q.rs1, ex_q.rs1_data, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                        bus.wb_reg_write, bus.wb_rd, bus.wb_result);
      rs2_fwd = fwd_sel(ex_q.rs2, ex_q.rs2_data, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                        bus.wb_reg_write, bus.wb_rd, bus.wb_result);
   end

   assign bus.alu_a         = rs1_fwd;
   assign bus.alu_b         = ex_q.alu_src ? ex_q.imm : rs2_fwd;
   assign bus.ex_store_data = rs2_fwd;
   assign bus.alu_op        = ex_q.alu_op;
   assign bus.ex_pc         = ex_q.pc;
   assign bus.ex_imm        = ex_q.imm;
   assign bus.ex_rd         = ex_q.rd;
   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_result_src = ex_q.result_src;

   // A slot that is not valid must not have side effects downstream.
   assign bus.ex_reg_write  = ex_q.valid & ex_q.reg_write;
   assign bus.ex_mem_read   = ex_q.valid & ex_q.mem_read;
   assign bus.ex_mem_write  = ex_q.valid & ex_q.mem_write;

   // Stores consume rs2 as data even when B takes the immediate.
   assign id_reads_rs2 = !bus.id_alu_src || bus.id_mem_write;

   assign bus.load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.id_valid &&
                                ((ex_q.rd == bus.id_rs1) || ((ex_q.rd == bus.id_rs2) && id_reads_rs2));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        alu_src;
      logic [2:0]  op;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [1:0]  rsrc;
   } id_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic chk_en;
   id_t  m;
   id_t  v;

   id_ex_operand_stage_if bus ();

   id_ex_operand_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input id_t x);
      bus.id_valid      = x.valid;
      bus.id_pc         = x.pc;
      bus.id_rs1_data   = x.rs1d;
      bus.id_rs2_data   = x.rs2d;
      bus.id_imm        = x.imm;
      bus.id_rs1        = x.rs1;
      bus.id_rs2        = x.rs2;
      bus.id_rd         = x.rd;
      bus.id_alu_src    = x.alu_src;
      bus.id_alu_op     = x.op;
      bus.id_reg_write  = x.rw;
      bus.id_mem_read   = x.mr;
      bus.id_mem_write  = x.mw;
      bus.id_result_src = x.rsrc;
   endtask

   task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                          input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
      bus.exm_reg_write = ew;
      bus.exm_rd        = erd;
      bus.exm_result    = eres;
      bus.wb_reg_write  = ww;
      bus.wb_rd         = wrd;
      bus.wb_result     = wres;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the instruction currently occupying EX, as the pipeline rules say it should be.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          m = '0;
      else if (bus.flush)  m = '0;
      else if (!bus.stall) m = '{bus.id_valid, bus.id_pc, bus.id_rs1_data, bus.id_rs2_data,
                                 bus.id_imm, bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_alu_src,
                                 bus.id_alu_op, bus.id_reg_write, bus.id_mem_read,
                                 bus.id_mem_write, bus.id_result_src};
   end

   function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
      if (r == 5'd0) return rf;
      if (bus.exm_reg_write && bus.exm_rd == r) return bus.exm_result;
      if (bus.wb_reg_write && bus.wb_rd == r) return bus.wb_result;
      return rf;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         logic [31:0] ea, es;
         logic        reads2, haz;
         ea     = operand(m.rs1, m.rs1d);
         es     = operand(m.rs2, m.rs2d);
         reads2 = (bus.id_alu_src == 1'b0) || bus.id_mem_write;
         haz    = m.valid && m.mr && m.rd != 5'd0 && bus.id_valid &&
                  (m.rd == bus.id_rs1 || (reads2 && m.rd == bus.id_rs2));
         chk("alu_a", bus.alu_a, ea);
         chk("alu_b", bus.alu_b, m.alu_src ? m.imm : es);
         chk("store_data", bus.ex_store_data, es);
         chk("pc_imm", {bus.ex_pc[15:0], bus.ex_imm[15:0]}, {m.pc[15:0], m.imm[15:0]});
         chk("ctrl", {21'd0, bus.alu_op, bus.ex_rd, bus.ex_valid, bus.ex_reg_write,
                      bus.ex_mem_read, bus.ex_mem_write, bus.ex_result_src},
                     {21'd0, m.op, m.rd, m.valid, m.valid & m.rw, m.valid & m.mr,
                      m.valid & m.mw, m.rsrc});
         chk("load_use", {31'd0, bus.load_use_hazard}, {31'd0, haz});
      end
   end

   initial begin
      total  = 0;
      bad    = 0;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drive('0);
      set_fwd(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      chk("rst_alu_b", bus.alu_b, 32'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // addi x3, x1, -3 with x1 = 5
      v = '0; v.valid = 1; v.pc = 32'h100; v.rs1 = 1; v.rs2 = 2; v.rd = 3;
      v.rs1d = 32'd5; v.rs2d = 32'd9; v.imm = 32'hFFFF_FFFD; v.alu_src = 1; v.rw = 1;
      drive(v);
      tick();
      chk("plain_a", bus.alu_a, 32'd5);
      chk("plain_b", bus.alu_b, 32'hFFFF_FFFD);
      chk("plain_rw", {31'd0, bus.ex_reg_write}, 32'd1);

      // sub with rs1 = x7 produced in both EX/MEM and MEM/WB
      v = '0; v.valid = 1; v.pc = 32'h104; v.rs1 = 7; v.rs2 = 8; v.rd = 4;
      v.rs1d = 32'h70; v.rs2d = 32'h80; v.op = 3'b001; v.rw = 1;
      drive(v);
      tick();
      set_fwd(1, 7, 32'h11, 1, 7, 32'h22);
      #1 chk("fwd_exm", bus.alu_a, 32'h11);
      chk("fwd_rs2_none", bus.alu_b, 32'h80);
      bus.exm_reg_write = 1'b0;
      #1 chk("fwd_wb", bus.alu_a, 32'h22);
      bus.wb_rd = 5'd8;
      #1 chk("fwd_wb_rs2", bus.ex_store_data, 32'h22);
      #1 set_fwd(0, 0, 0, 0, 0, 0);

      // x0 never forwards
      v = '0; v.valid = 1; v.pc = 32'h108; v.rs1 = 1; v.rs2 = 0; v.rd = 5; v.rs1d = 32'd1;
      drive(v);
      tick();
      set_fwd(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
      #1 chk("x0_b", bus.alu_b, 32'd0);
      chk("x0_store", bus.ex_store_data, 32'd0);
      set_fwd(0, 0, 0, 0, 0, 0);

      // stall holds for three cycles while decode changes underneath
      v = '0; v.valid = 1; v.pc = 32'h200; v.rd = 9; v.rw = 1; v.op = 3'b110;
      drive(v);
      tick();
      bus.stall = 1'b1;
      v.pc = 32'h300; v.rd = 10; v.op = 3'b010;
      drive(v);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", bus.ex_pc, 32'h200);
         chk("stall_op", {29'd0, bus.alu_op}, 32'd6);
      end
      bus.flush = 1'b1;
      tick();
      chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("flush_rd", {27'd0, bus.ex_rd}, 32'd0);
      bus.stall = 1'b0;
      bus.flush = 1'b0;

      // lw x5, 0(x2) in EX
      v = '0; v.valid = 1; v.pc = 32'h400; v.rs1 = 2; v.rd = 5; v.alu_src = 1;
      v.rw = 1; v.mr = 1; v.rsrc = 2'b01;
      drive(v);
      tick();
      v = '0; v.valid = 1; v.rs1 = 5; v.rs2 = 1; v.rd = 6; v.rw = 1;
      drive(v);
      #1 chk("lu_add", {31'd0, bus.load_use_hazard}, 32'd1);
      v = '0; v.valid = 1; v.rs1 = 1; v.rs2 = 5; v.rd = 6; v.alu_src = 1; v.imm = 32'd4; v.rw = 1;
      drive(v);
      #1 chk("lu_addi", {31'd0, bus.load_use_hazard}, 32'd0);
      v.mw = 1; v.rw = 0; v.rd = 0;
      drive(v);
      #1 chk("lu_store", {31'd0, bus.load_use_hazard}, 32'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("lu_bubble", {31'd0, bus.load_use_hazard}, 32'd0);

      // invalid slot must not carry side effects
      v = '0; v.valid = 0; v.rd = 7; v.rw = 1; v.mr = 1; v.mw = 1;
      drive(v);
      tick();
      chk("inv_ctrl", {29'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 32'd0);

      for (int i = 0; i < 24; i++) begin
         v.valid   = 1'($urandom_range(0, 3) != 0);
         v.pc      = $urandom;
         v.rs1d    = $urandom;
         v.rs2d    = $urandom;
         v.imm     = $urandom;
         v.rs1     = 5'($urandom_range(0, 3));
         v.rs2     = 5'($urandom_range(0, 3));
         v.rd      = 5'($urandom_range(0, 3));
         v.alu_src = 1'($urandom_range(0, 1));
         v.op      = 3'($urandom_range(0, 7));
         v.rw      = 1'($urandom_range(0, 1));
         v.mr      = 1'($urandom_range(0, 1));
         v.mw      = 1'($urandom_range(0, 1));
         v.rsrc    = 2'($urandom_range(0, 3));
         drive(v);
         bus.stall = 1'($urandom_range(0, 3) == 0);
         bus.flush = 1'($urandom_range(0, 5) == 0);
         set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
         tick();
      end
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      set_fwd(0, 0, 0, 0, 0, 0);

      // asynchronous reset in the middle of a cycle
      v = '0; v.valid = 1; v.pc = 32'h500; v.rs1d = 32'h55; v.rs2d = 32'h66; v.op = 3'b100;
      drive(v);
      tick();
      chk("pre_rst_a", bus.alu_a, 32'h55);
      #2 rst_n = 1'b0;
      #1 chk("arst_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("arst_op", {29'd0, bus.alu_op}, 32'd0);
      chk("arst_a", bus.alu_a, 32'd0);
      chk("arst_b", bus.alu_b, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
